// File: rtl/prim_onehot_pkg.sv
// Shared one-hot helpers and defaults for demux/mux primitives.
// Contents: ErrCntWDef (error counter width), OnehotMaxW, onehot_ok().
package prim_onehot_pkg;

    localparam int ErrCntWDef = 8;
    localparam int OnehotMaxW = 64;

    // Callers zero-extend their vector to OnehotMaxW; padding zeros do
    // not change the one-hot outcome.
    function automatic logic onehot_ok(input logic [OnehotMaxW-1:0] vec);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < OnehotMaxW; i++) begin
            multi = multi | (seen & vec[i]);
            seen  = seen | vec[i];
        end
        return seen & ~multi;
    endfunction

endpackage

// File: rtl/prim_onehot_demux_slot.sv
// Single-entry holding register for one demux output channel.
// Ports: clk_i, rst_i, wr_i (load), drain_i (consumer took beat),
//        data_i, valid_o, data_o.
module prim_onehot_demux_slot #(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_i,
    input  logic             drain_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    // A write wins over a drain, so drain+write keeps the slot full.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            if (wr_i) begin
                valid_o <= 1'b1;
                data_o  <= data_i;
            end else if (drain_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/prim_onehot_demux_reg.sv
// Registered one-hot demux: one valid/ready stream to Outputs channels.
// Ports: clk_i, rst_i, in_valid_i/in_ready_o/in_data_i/in_sel_i,
//        out_valid_o/out_ready_i/out_data_o, err_clr_i, err_o, err_cnt_o.
module prim_onehot_demux_reg
    import prim_onehot_pkg::*;
#(
    parameter int Width   = 32,
    parameter int Outputs = 8,
    parameter int ErrCntW = ErrCntWDef
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [Width-1:0]   in_data_i,
    input  logic [Outputs-1:0] in_sel_i,
    output logic [Outputs-1:0] out_valid_o,
    input  logic [Outputs-1:0] out_ready_i,
    output logic [Width-1:0]   out_data_o [Outputs],
    input  logic               err_clr_i,
    output logic               err_o,
    output logic [ErrCntW-1:0] err_cnt_o
);

    logic [OnehotMaxW-1:0] sel_ext;
    logic                  sel_ok;
    logic [Outputs-1:0]    drain;
    logic [Outputs-1:0]    wr;
    logic                  acc;
    logic                  bad;

    assign sel_ext = OnehotMaxW'(in_sel_i);
    assign sel_ok  = onehot_ok(sel_ext);
    assign drain   = out_valid_o & out_ready_i;

    // Bad selects are always taken so a broken producer cannot deadlock.
    assign in_ready_o = sel_ok ? |(in_sel_i & (~out_valid_o | drain))
                               : 1'b1;

    assign acc = in_valid_i & in_ready_o;
    assign wr  = {Outputs{acc & sel_ok}} & in_sel_i;
    assign bad = acc & ~sel_ok;

    for (genvar k = 0; k < Outputs; k++) begin : gen_slot
        prim_onehot_demux_slot #(
            .Width (Width)
        ) u_slot (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .wr_i    (wr[k]),
            .drain_i (drain[k]),
            .data_i  (in_data_i),
            .valid_o (out_valid_o[k]),
            .data_o  (out_data_o[k])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else if (err_clr_i) begin
            // A bad beat in the clearing cycle is the first new error.
            err_o     <= bad;
            err_cnt_o <= bad ? ErrCntW'(1) : '0;
        end else if (bad) begin
            err_o <= 1'b1;
            if (err_cnt_o != '1) begin
                err_cnt_o <= err_cnt_o + ErrCntW'(1);
            end
        end
    end

    logic [Outputs-1:0] prev_hold;
    logic [Width-1:0]   prev_data [Outputs];

    always_ff @(posedge clk_i) begin
        prev_hold <= rst_i ? '0 : (out_valid_o & ~out_ready_i);
        prev_data <= out_data_o;
        for (int k = 0; k < Outputs; k++) begin
            if (!rst_i && prev_hold[k]) begin
                assert (out_valid_o[k] && out_data_o[k] == prev_data[k]);
            end
        end
        if (!rst_i && in_valid_i && !in_ready_o) begin
            assert (sel_ok);
        end
    end

endmodule

// File: tb/tb_prim_onehot_demux_reg.sv
// Randomized + directed bench for prim_onehot_demux_reg.
// Reference: per-channel queues of accepted beats and an error tally.
module tb_prim_onehot_demux_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [7:0]  in_sel;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [31:0] out_data [8];
    logic        err_clr;
    logic        err;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    prim_onehot_demux_reg #(
        .Width   (32),
        .Outputs (8),
        .ErrCntW (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_sel_i    (in_sel),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .err_clr_i   (err_clr),
        .err_o       (err),
        .err_cnt_o   (err_cnt)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mq [8][$];
    int          mcnt = 0;
    bit          merr = 1'b0;
    bit          known = 1'b0;
    logic        last_rdy;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("valid%0d", k), 64'(out_valid[k]),
                64'(mq[k].size() != 0));
            if (mq[k].size() != 0)
                chk($sformatf("data%0d", k), 64'(out_data[k]), 64'(mq[k][0]));
        end
        chk("err", 64'(err), 64'(merr));
        chk("err_cnt", 64'(err_cnt), 64'(mcnt));
    endtask

    task automatic cycle(input logic v, input logic [7:0] sel,
                         input logic [31:0] d, input logic [7:0] ordy,
                         input logic clr, input logic r);
        bit ok;
        bit rdy;
        bit acc;
        int idx;
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        out_ready = ordy;
        err_clr   = clr;
        rst       = r;
        #1;
        ok  = ($countones(sel) == 1);
        idx = 0;
        for (int k = 0; k < 8; k++) if (sel[k]) idx = k;
        rdy = ok ? (mq[idx].size() == 0 || ordy[idx]) : 1'b1;
        last_rdy = in_ready;
        if (known) chk("in_ready", 64'(in_ready), 64'(rdy));
        @(posedge clk);
        #1;
        if (r) begin
            for (int k = 0; k < 8; k++) mq[k].delete();
            merr  = 1'b0;
            mcnt  = 0;
            known = 1'b1;
        end else if (known) begin
            acc = v && rdy;
            for (int k = 0; k < 8; k++)
                if (mq[k].size() != 0 && ordy[k]) void'(mq[k].pop_front());
            if (acc && ok) mq[idx].push_back(d);
            if (clr) begin
                merr = acc && !ok;
                mcnt = (acc && !ok) ? 1 : 0;
            end else if (acc && !ok) begin
                merr = 1'b1;
                if (mcnt < 255) mcnt++;
            end
        end
        if (known) check_outputs();
    endtask

    function automatic logic [7:0] bad_sel();
        logic [7:0] s;
        if ($urandom_range(0, 1) == 0) return 8'h00;
        do s = 8'($urandom); while ($countones(s) == 1);
        return s;
    endfunction

    initial begin
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        err_clr   = 1'b0;
        rst       = 1'b1;

        // reset with a pending beat
        cycle(1, 8'h04, 32'h11, 8'h00, 0, 1);
        chk("rst_valid_a", 64'(out_valid), 64'h0);
        chk("rst_cnt_a", 64'(err_cnt), 64'h0);
        cycle(1, 8'h04, 32'h11, 8'h00, 0, 1);
        chk("rst_valid_b", 64'(out_valid), 64'h0);
        chk("rst_rdy", 64'(last_rdy), 64'h1);
        cycle(1, 8'h04, 32'h11, 8'h00, 0, 0);
        chk("post_rst_load", 64'(out_valid), 64'h04);
        cycle(0, 8'h00, 32'h0, 8'hff, 0, 0);

        // single beat, stall on same slot, parallel accept
        cycle(1, 8'h04, 32'hDEADBEEF, 8'h00, 0, 0);
        chk("single_valid", 64'(out_valid), 64'h04);
        chk("single_data", 64'(out_data[2]), 64'hDEADBEEF);
        cycle(1, 8'h04, 32'hCAFEF00D, 8'h00, 0, 0);
        chk("stall_rdy", 64'(last_rdy), 64'h0);
        cycle(1, 8'h01, 32'h00001234, 8'h00, 0, 0);
        chk("par_rdy", 64'(last_rdy), 64'h1);
        chk("par_valid", 64'(out_valid), 64'h05);
        chk("par_data2", 64'(out_data[2]), 64'hDEADBEEF);
        cycle(0, 8'h00, 32'h0, 8'hff, 0, 0);

        // streaming into channel 7
        for (int i = 0; i < 16; i++) begin
            cycle(1, 8'h80, 32'(i), 8'h80, 0, 0);
            chk("stream_rdy", 64'(last_rdy), 64'h1);
            chk("stream_data", 64'(out_data[7]), 64'(i));
        end
        cycle(0, 8'h00, 32'h0, 8'hff, 0, 0);

        // backpressure on channel 3
        cycle(1, 8'h08, 32'd100, 8'h00, 0, 0);
        for (int j = 0; j < 4; j++) begin
            logic b;
            b = 1'(j % 2);
            cycle(1, 8'h08, 32'(200 + j), {4'b0, b, 3'b0}, 0, 0);
            chk("bp_rdy", 64'(last_rdy), 64'(b));
        end
        cycle(0, 8'h00, 32'h0, 8'hff, 0, 0);

        // bad selects, saturation, clear
        cycle(1, 8'h00, 32'h1, 8'h00, 0, 0);
        chk("bad0_rdy", 64'(last_rdy), 64'h1);
        cycle(1, 8'h06, 32'h2, 8'h00, 0, 0);
        chk("bad1_rdy", 64'(last_rdy), 64'h1);
        chk("bad_valid", 64'(out_valid), 64'h0);
        chk("bad_err", 64'(err), 64'h1);
        chk("bad_cnt2", 64'(err_cnt), 64'd2);
        for (int i = 0; i < 300; i++) cycle(1, 8'h00, 32'(i), 8'h00, 0, 0);
        chk("sat_cnt", 64'(err_cnt), 64'd255);
        cycle(1, 8'h03, 32'h3, 8'h00, 1, 0);
        chk("clr_bad_cnt", 64'(err_cnt), 64'd1);
        chk("clr_bad_err", 64'(err), 64'h1);
        cycle(0, 8'h00, 32'h0, 8'h00, 1, 0);
        chk("clr_cnt", 64'(err_cnt), 64'd0);
        chk("clr_err", 64'(err), 64'h0);

        // random traffic
        for (int i = 0; i < 10000; i++) begin
            logic [7:0] s;
            if ($urandom_range(0, 9) == 0) s = bad_sel();
            else s = 8'(1 << $urandom_range(0, 7));
            cycle($urandom_range(0, 9) < 8, s, $urandom, 8'($urandom),
                  $urandom_range(0, 199) == 0, i == 5000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prim_onehot_demux_reg.md
Name: prim_onehot_demux_reg

Overview:
- Registered one-hot demultiplexer: the distribution counterpart of the AND/OR one-hot mux.
- Routes one valid/ready input stream to one of Outputs channels, selected by a one-hot destination vector.
- Each output channel has a single-entry holding register.
- Non-one-hot selects are rejected, flagged and counted.
- Sits between a single producer (decode/arbitration stage) and N independent consumers.

Parameters:
- Width, 32, data bits per beat.
- Outputs, 8, number of destination channels (>=2).
- ErrCntW, 8, width of saturating error counter.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous, active-high reset.
- in_valid_i  input  1  input beat valid.
- in_ready_o  output  1  input beat accepted when in_valid_i & in_ready_o.
- in_data_i  input  Width  input payload.
- in_sel_i  input  Outputs  destination select; must be one-hot.
- out_valid_o  output  Outputs  per-channel valid.
- out_ready_i  input  Outputs  per-channel consumer ready.
- out_data_o  output  Width x Outputs (unpacked array [Outputs])  per-channel payload.
- err_clr_i  input  1  clears err_o and err_cnt_o.
- err_o  output  1  sticky: a non-one-hot select was accepted.
- err_cnt_o  output  ErrCntW  saturating count of rejected beats.

Behaviour:
- Reset (clk_i edge with rst_i=1):
  - all out_valid_o=0, all out_data_o=0, err_o=0, err_cnt_o=0.
  - in_ready_o is combinational and reflects the cleared slots during and after reset.
  - Reset mid-transfer drops held beats; no partial outputs.
- Slot state per channel k: EMPTY (out_valid_o[k]=0) or FULL (out_valid_o[k]=1).
  - EMPTY->FULL on a write.
  - FULL->EMPTY on a drain without write.
  - FULL->FULL on a simultaneous drain and write; data is replaced by the new beat.
- drain[k] = out_valid_o[k] & out_ready_i[k].
- sel_ok = $onehot(in_sel_i); zero or multi-hot is invalid.
- in_ready_o:
  - If sel_ok: 1 when the selected slot is EMPTY or drain of that slot is true (OR-reduce of in_sel_i & (~out_valid_o | drain)).
  - If !sel_ok: 1 (the bad beat is consumed to avoid deadlock).
  - in_ready_o depends combinationally on out_ready_i; no combinational path from in_valid_i to in_ready_o.
- Write: in_valid_i & in_ready_o & sel_ok loads in_data_i into the selected slot and sets its valid. Latency 1 cycle: data is visible on out_data_o the cycle after acceptance.
- Throughput: 1 beat/cycle per channel under continuous out_ready_i. Independent channels never block each other.
- out_data_o[k] holds its value while FULL and not drained. It is unchanged (not cleared) after a drain.
- out_valid_o[k] never drops without drain[k] or reset.
- Rejected beat (accepted with !sel_ok): no slot changes, err_o set, err_cnt_o increments and saturates at 2^ErrCntW-1.
- err_clr_i:
  - Alone: err_o=0, err_cnt_o=0 next cycle.
  - With a simultaneous rejected beat: err_o=1, err_cnt_o=1.
- Assertions:
  - out_valid_o[k] & !out_ready_i[k] implies stable valid and data next cycle.
  - in_valid_i & !in_ready_o implies sel_ok.

Decomposition:
- Package prim_onehot_pkg:
  - ErrCntW default constant.
  - Function onehot_ok(logic [N-1:0]) returning the one-hot check, shared with mux-side checkers.
- Sub-module prim_onehot_demux_slot:
  - One holding register (valid+data) with wr_i, drain_i, data_i, valid_o, data_o.
  - Instantiated Outputs times in a generate loop.
- Error logic stays in the top.

Test Plan:
- Reset check: assert rst_i for 2 cycles with in_valid_i=1, sel=8'h04 -> out_valid_o=0, err_cnt_o=0 throughout reset; slot 2 loads 1 cycle after rst_i deasserts.
- Single beat: data=32'hDEADBEEF, sel=8'h04, out_ready_i=0 -> cycle+1 out_valid_o=8'h04, out_data_o[2]=DEADBEEF. Then:
  - A second beat to sel=8'h04 stalls (in_ready_o=0).
  - A beat to sel=8'h01 is accepted in parallel.
- Streaming: 16 back-to-back beats data=i to sel=8'h80 with out_ready_i[7]=1 -> in_ready_o stays 1, channel 7 outputs 0..15 in order, one per cycle, no bubbles.
- Backpressure: slot 3 FULL, out_ready_i[3] toggles 0,1,0,1 with beats pending -> accepted only in cycles where out_ready_i[3]=1; no loss, no duplication.
- Bad select: sel=8'h00 then 8'h06, both valid -> in_ready_o=1, no out_valid_o change, err_o=1, err_cnt_o=2. Then 300 bad beats -> err_cnt_o=255. Then err_clr_i together with a bad beat -> err_cnt_o=1.
- Random: random sel (10% invalid), random out_ready_i for 10k cycles vs. scoreboard -> per-channel ordering exact, err_cnt_o equals the invalid count, saturating.
